// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and sizing helper for the BCD-to-binary converter.
// No logic of its own, so no latency or backpressure.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0] DD_THRESH_DN  = 4'd8;
    localparam logic [3:0] DD_CORR       = 4'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } bcd_state_e;

    // Smallest digit count whose all-nines value reaches 2^w-1.
    function automatic int bcd_digits_for(input int w);
        longint lim;
        longint p;
        int     d;
        lim = (longint'(1) << w) - 1;
        p   = 1;
        d   = 0;
        for (int i = 0; i < 20; i++) begin
            if (p - 1 < lim) begin
                p = p * 10;
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_dn.sv
// One reverse double-dabble correction: subtract 3 from a BCD nibble that reached 8 or more.
// Purely combinational, zero latency, no backpressure.
module bcd_digit_dn
    import bcd_pkg::*;
(
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);

    always_comb begin
        d_out = d_in;
        if (d_in >= DD_THRESH_DN) begin
            d_out = d_in - DD_CORR;
        end
    end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter, one result bit per clock; result valid W cycles after accept.
// Single conversion in flight: in_ready only in IDLE or while a held DONE result is being taken.
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int W      = 20,
    parameter int DIGITS = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          bin_out,
    output logic                  overflow,
    output logic                  bad_digit
);

    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    bcd_state_e          state_q, state_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [W-1:0]        bin_q, bin_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                bad_q, bad_d;

    logic [4*DIGITS-1:0] bcd_shift;
    logic [4*DIGITS-1:0] bcd_step;
    logic [W-1:0]        bin_step;
    logic [DIGITS-1:0]   bad_vec;
    logic                accept;

    // Bit shifted out of the BCD side becomes the next binary MSB.
    assign bcd_shift = {1'b0, bcd_q[4*DIGITS-1:1]};
    assign bin_step  = {bcd_q[0], bin_q[W-1:1]};

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_dn u_dn (
            .d_in  (bcd_shift[4*i +: 4]),
            .d_out (bcd_step[4*i +: 4])
        );
        assign bad_vec[i] = (bcd_in[4*i +: 4] > BCD_MAX_DIGIT);
    end

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign bin_out   = bin_q;
    assign overflow  = ovf_q;
    assign bad_digit = bad_q;

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        bad_d   = bad_q;

        case (state_q)
            CONV: begin
                bcd_d = bcd_step;
                bin_d = bin_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    // Anything left on the BCD side is value >> W.
                    ovf_d   = |bcd_step;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // A load out of DONE skips IDLE entirely.
        if (accept) begin
            state_d = CONV;
            bcd_d   = bcd_in;
            bin_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            bad_d   = |bad_vec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            bad_q   <= bad_d;
        end
    end

endmodule
